// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage. It owns the program counter and drives the
//   instruction memory address combinationally from that PC. The returned
//   word is captured into the IF/ID pipeline register for the decoder.
//
//   The next state is chosen each cycle in this priority order:
//     1. redirect - load the EX target and flush IF/ID
//     2. fault    - the PC is out of range: set the sticky fault and insert a bubble
//     3. stall    - hold everything
//     4. normal   - capture the fetched word and advance the PC
//
//   Optional feature macro: FETCH_JAL_PREDICT_EN
//     Defined   : a JAL seen during a normal fetch is followed immediately to its
//                 target, and the instruction is marked as predicted in IF/ID.
//     Undefined : next PC is always PC+4, and if_id_pred_o is tied to 0.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic        if_id_pred_o,
    output logic        fetch_fault_o
);

    // First byte address past the end of instruction memory.
    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

    logic [31:0] pc_q,       pc_d;
    logic [31:0] if_pc_q,    if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;
    logic        if_pred_q,  if_pred_d;
    logic        fault_q,    fault_d;

    logic        out_of_range_s;
    logic        jal_hit_s;
    logic [31:0] next_pc_s;

    assign imem_addr_o    = pc_q;
    assign out_of_range_s = (pc_q >= PC_LIMIT);

`ifdef FETCH_JAL_PREDICT_EN
    logic [31:0] jal_imm_s;
    logic [31:0] jal_target_s;

    // Predecode JAL and compute its word-aligned target from the J-immediate.
    always_comb begin
        jal_hit_s    = 1'b0;
        jal_imm_s    = {{11{imem_data_i[31]}}, imem_data_i[31], imem_data_i[19:12],
                        imem_data_i[20], imem_data_i[30:21], 1'b0};
        jal_target_s = (pc_q + jal_imm_s) & ~32'h0000_0003;
        if (imem_data_i[6:0] == 7'b1101111) begin
            jal_hit_s = 1'b1;
        end else begin
            jal_hit_s = 1'b0;
        end
    end

    // Next sequential PC, or the JAL target when a JAL is predicted taken.
    always_comb begin
        next_pc_s = pc_q + 32'd4;
        if (jal_hit_s) begin
            next_pc_s = jal_target_s;
        end else begin
            next_pc_s = pc_q + 32'd4;
        end
    end
`else
    // Without predecode, the PC simply advances by one word (wrapping at 2^32).
    always_comb begin
        jal_hit_s = 1'b0;
        next_pc_s = pc_q + 32'd4;
    end
`endif

    // Select the next PC and IF/ID contents by priority: redirect, fault, stall, normal.
    always_comb begin
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        if_pred_d  = if_pred_q;
        fault_d    = fault_q;
        if (redirect_i) begin
            pc_d       = redirect_pc_i & ~32'h0000_0003;
            if_pc_d    = 32'h0000_0000;
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
            if_pred_d  = 1'b0;
            fault_d    = 1'b0;
        end else if (out_of_range_s) begin
            // The PC holds here, so the fault condition persists until a redirect.
            if_pc_d    = 32'h0000_0000;
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
            if_pred_d  = 1'b0;
            fault_d    = 1'b1;
        end else if (stall_i) begin
            pc_d       = pc_q;
            if_pc_d    = if_pc_q;
        end else begin
            pc_d       = next_pc_s;
            if_pc_d    = pc_q;
            if_instr_d = imem_data_i;
            if_valid_d = 1'b1;
            if_pred_d  = jal_hit_s;
        end
    end

    // PC, IF/ID and fault state; async reset returns the decoder to a legal bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            if_pc_q    <= 32'h0000_0000;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
            if_pred_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            if_pred_q  <= if_pred_d;
            fault_q    <= fault_d;
        end
    end

    assign if_id_pc_o    = if_pc_q;
    assign if_id_instr_o = if_instr_q;
    assign if_id_valid_o = if_valid_q;
`ifdef FETCH_JAL_PREDICT_EN
    assign if_id_pred_o  = if_pred_q;
`else
    assign if_id_pred_o  = 1'b0;
`endif
    assign fetch_fault_o = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. A 256-word instruction memory model
//   returns data combinationally. Inputs are driven on falling edges, and
//   outputs are checked on the falling edge that follows each rising edge.
//   JAL expectations depend on FETCH_JAL_PREDICT_EN.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        if_id_pred;
    logic        fetch_fault;

    logic [31:0] mem [0:255];
    int          n_checks;
    int          n_errors;

`ifdef FETCH_JAL_PREDICT_EN
    localparam logic [31:0] EXP_AFTER_JAL  = 32'h0000_0018;
    localparam logic [31:0] EXP_PRED       = 32'h0000_0001;
`else
    localparam logic [31:0] EXP_AFTER_JAL  = 32'h0000_000C;
    localparam logic [31:0] EXP_PRED       = 32'h0000_0000;
`endif

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .if_id_pc_o    (if_id_pc),
        .if_id_instr_o (if_id_instr),
        .if_id_valid_o (if_id_valid),
        .if_id_pred_o  (if_id_pred),
        .fetch_fault_o (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational memory model; out-of-range addresses return a marker word.
    always_comb begin
        if (imem_addr < 32'h0000_0400) imem_data = mem[imem_addr[9:2]];
        else                           imem_data = 32'hDEAD_BEEF;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic valid, input logic [31:0] addr);
        check_val({tag, "_pc"},    if_id_pc,           pc);
        check_val({tag, "_instr"}, if_id_instr,        instr);
        check_val({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
        check_val({tag, "_addr"},  imem_addr,          addr);
    endtask

    task automatic check_reset_vals(input string tag);
        check_ifid(tag, 32'h0000_0000, 32'h0000_0013, 1'b0, 32'h0000_0000);
        check_val({tag, "_pred"},  {31'd0, if_id_pred},  32'd0);
        check_val({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        // ADDI x0,x0,i in every word, with specific words overwritten below.
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
        mem[0] = 32'h0050_0093;
        mem[2] = 32'h0100_006F;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        // Reset state.
        #12;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Normal fetch from 0.
        step();
        check_ifid("f0", 32'h0, 32'h0050_0093, 1'b1, 32'h4);
        step();
        check_ifid("f4", 32'h4, 32'h0010_0013, 1'b1, 32'h8);

        // Stall for three cycles with the PC at 8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ifid("stall", 32'h4, 32'h0010_0013, 1'b1, 32'h8);
        end
        stall = 1'b0;
        step();
        check_ifid("resume", 32'h8, 32'h0100_006F, 1'b1, EXP_AFTER_JAL);
        check_val("jal_pred", {31'd0, if_id_pred}, EXP_PRED);

        // Redirect takes priority over stall; low address bits are dropped.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0043;
        step();
        check_ifid("redir", 32'h0, 32'h0000_0013, 1'b0, 32'h40);
        check_val("redir_pred", {31'd0, if_id_pred}, 32'd0);
        stall = 1'b0; redirect = 1'b0;
        step();
        check_ifid("tgt", 32'h40, 32'h0100_0013, 1'b1, 32'h44);

        // Fetch the last legal word, then run off the end of memory.
        redirect = 1'b1; redirect_pc = 32'h0000_03FC;
        step();
        redirect = 1'b0;
        check_val("edge_addr", imem_addr, 32'h3FC);
        step();
        check_ifid("last", 32'h3FC, 32'h0FF0_0013, 1'b1, 32'h400);
        check_val("last_fault", {31'd0, fetch_fault}, 32'd0);
        step();
        check_ifid("flt", 32'h0, 32'h0000_0013, 1'b0, 32'h400);
        check_val("flt_set", {31'd0, fetch_fault}, 32'd1);
        stall = 1'b1;
        step();
        check_ifid("flt_st", 32'h0, 32'h0000_0013, 1'b0, 32'h400);
        check_val("flt_sticky", {31'd0, fetch_fault}, 32'd1);
        stall = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0000_0000;
        step();
        redirect = 1'b0;
        check_val("flt_clr", {31'd0, fetch_fault}, 32'd0);
        check_val("flt_clr_addr", imem_addr, 32'h0);
        step();
        check_ifid("refetch", 32'h0, 32'h0050_0093, 1'b1, 32'h4);

        // Asynchronous reset between clock edges.
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_ifid("post_rst", 32'h0, 32'h0050_0093, 1'b1, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
